filter_seq_ctrl: RTL

- Sequencer for the single-pole IIR filter datapath, which has two 16x8 shift-add multipliers and an output register.
- Per sample: turns an incoming sample request into a one-cycle multiplier clear, MULT_CYCLES cycles of shift enable, and a one-cycle output-register commit strobe.
- Owns the live filter coefficients. Host writes are staged and applied only at sample boundaries, so a computation never sees mixed coefficients.
- Sits between the audio sample-rate source and the filter.

---
 rtl/filter_seq_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/filter_seq_ctrl.sv
// filter_seq_ctrl: sequencer for a single-pole IIR filter datapath built from two
// 16x8 shift-add multipliers and an output register.
//
// Per accepted sample request it issues a one-cycle multiplier clear (mult_rst),
// MULT_CYCLES cycles of shift enable (mult_en), a one-cycle output-register commit
// (sample_strobe), then a one-cycle dout_valid. It owns the live coefficients
// coef_a/coef_b. Host writes land in pending registers and are copied to the live
// registers only when a sample starts, so one computation never sees a mix of old
// and new coefficients.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   sample_req      one-cycle request to process a new sample
//   cfg_we          stage cfg_a/cfg_b into the pending registers
//   cfg_a, cfg_b    feedback / input coefficient write data
//   ovr_clr         clear the sticky overrun flag
//   mult_rst        multiplier clear pulse (CLEAR)
//   mult_en         multiplier shift enable (RUN)
//   sample_strobe   output-register clock enable (COMMIT)
//   coef_a, coef_b  live coefficients
//   busy            high whenever the sequencer is not idle
//   dout_valid      new filter output available (DONE)
//   overrun         sticky, set when a request arrives while busy
//
// Build option: define FILTER_SEQ_AUTOTICK_EN to generate requests internally every
// SAMPLE_DIV clocks; sample_req is then ignored.
module filter_seq_ctrl #(
  parameter int unsigned MULT_CYCLES = 8,
  parameter logic [7:0]  A_RST       = 8'd224,
  parameter logic [7:0]  B_RST       = 8'd32,
  parameter int unsigned SAMPLE_DIV  = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_req,
  input  logic       cfg_we,
  input  logic [7:0] cfg_a,
  input  logic [7:0] cfg_b,
  input  logic       ovr_clr,
  output logic       mult_rst,
  output logic       mult_en,
  output logic       sample_strobe,
  output logic [7:0] coef_a,
  output logic [7:0] coef_b,
  output logic       busy,
  output logic       dout_valid,
  output logic       overrun
);

  localparam int unsigned    CntW    = $clog2(MULT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MULT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StClear, StRun, StCommit, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        coef_a_q, coef_a_d, coef_b_q, coef_b_d;
  logic [7:0]        pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic              ovr_q, ovr_d;
  logic              req;

`ifdef FILTER_SEQ_AUTOTICK_EN
  localparam int unsigned      TickW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(SAMPLE_DIV - 1);

  // A divider shorter than one full sample sequence would overrun on every tick.
  if (SAMPLE_DIV < MULT_CYCLES + 4) begin : g_bad_div
    $error("filter_seq_ctrl: SAMPLE_DIV must be >= MULT_CYCLES+4");
  end

  logic [TickW-1:0] tick_q, tick_d;
  logic             unused_sample_req;

  assign unused_sample_req = sample_req;

  always_comb begin
    tick_d = (tick_q == TickLast) ? '0 : tick_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_q <= '0;
    else     tick_q <= tick_d;
  end

  assign req = (tick_q == TickLast);
`else
  assign req = sample_req;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    coef_a_d = coef_a_q;
    coef_b_d = coef_b_q;
    pend_a_d = cfg_we ? cfg_a : pend_a_q;
    pend_b_d = cfg_we ? cfg_b : pend_b_q;
    ovr_d    = ovr_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d  = StClear;
          // Same-cycle write bypasses the pending register and applies to this sample.
          coef_a_d = cfg_we ? cfg_a : pend_a_q;
          coef_b_d = cfg_we ? cfg_b : pend_b_q;
        end
      end
      StClear: begin
        state_d = StRun;
        cnt_d   = '0;
      end
      StRun: begin
        if (cnt_q == CntLast) state_d = StCommit;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      StCommit: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // A request while busy is dropped; set wins over clear.
    if (req && (state_q != StIdle)) ovr_d = 1'b1;
    else if (ovr_clr)               ovr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      coef_a_q <= A_RST;
      coef_b_q <= B_RST;
      pend_a_q <= A_RST;
      pend_b_q <= B_RST;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      coef_a_q <= coef_a_d;
      coef_b_q <= coef_b_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    mult_rst      = (state_q == StClear);
    mult_en       = (state_q == StRun);
    sample_strobe = (state_q == StCommit);
    dout_valid    = (state_q == StDone);
    busy          = (state_q != StIdle);
  end

  assign coef_a  = coef_a_q;
  assign coef_b  = coef_b_q;
  assign overrun = ovr_q;

endmodule
